// File: rtl/blue_pkg.sv
// rtl/blue_pkg.sv - shared op codes, error codes and FSM states for the Blue sequencer
package blue_pkg;

   // Result-mux select codes
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_SUB  = 3'b101;
   localparam logic [2:0] OP_OR   = 3'b110;
   localparam logic [2:0] OP_AND  = 3'b111;
   localparam logic [2:0] OP_XOR  = 3'b000;
   localparam logic [2:0] OP_SHR  = 3'b001;
   localparam logic [2:0] OP_MOV  = 3'b010;
   localparam logic [2:0] OP_EXCH = 3'b011;

   localparam int HALT_BIT = 7;

   localparam logic [1:0] ERR_OK   = 2'b00;
   localparam logic [1:0] ERR_TMO  = 2'b01;
   localparam logic [1:0] ERR_WRAP = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_WRITE = 3'd3,
      ST_FIN   = 3'd4
   } state_t;

endpackage

// File: rtl/blue_seq_ctrl_if.sv
// rtl/blue_seq_ctrl_if.sv - start/done, instruction fetch and datapath control bundle
interface blue_seq_ctrl_if #(
   parameter int PC_W = 4
);
   logic            start;
   logic [PC_W-1:0] start_pc;
   logic            instr_req;
   logic [PC_W-1:0] instr_addr;
   logic            instr_ack;
   logic [7:0]      instr_data;
   logic [2:0]      sel;
   logic            ld_a;
   logic            ld_b;
   logic            busy;
   logic            done;
   logic [1:0]      err;

   // Sequencer side
   modport master (
      input  start, start_pc, instr_ack, instr_data,
      output instr_req, instr_addr, sel, ld_a, ld_b, busy, done, err
   );

   // Environment side: top-level control, instruction ROM, datapath
   modport slave (
      output start, start_pc, instr_ack, instr_data,
      input  instr_req, instr_addr, sel, ld_a, ld_b, busy, done, err
   );
endinterface

// File: rtl/blue_fetch_tmo.sv
// rtl/blue_fetch_tmo.sv - fetch timeout counter with clear, enable and expire
module blue_fetch_tmo #(
   parameter int TMO_CYC = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);
   localparam int CW = $clog2(TMO_CYC + 1);

   logic [CW-1:0] cnt_q;

   // Expire on the last allowed fetch cycle so the abort lands after exactly TMO_CYC cycles
   assign expire_o = (cnt_q == CW'(TMO_CYC - 1));

   // Count fetch cycles; saturate at expiry, clear on each new fetch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && !expire_o) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/blue_seq_ctrl.sv
// rtl/blue_seq_ctrl.sv - fetch/exec/write sequencer driving the Blue result mux and RA/RB loads
module blue_seq_ctrl
   import blue_pkg::*;
#(
   parameter int PC_W    = 4,
   parameter int TMO_CYC = 15
) (
   input  logic           clk,
   input  logic           rst_n,
   blue_seq_ctrl_if.master bus
);
   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [2:0]      op_q, op_d;
   logic [2:0]      sel_q, sel_d;
   logic [1:0]      err_q, err_d;
   logic            tmo_clr;
   logic            tmo_exp;

   blue_fetch_tmo #(.TMO_CYC(TMO_CYC)) u_tmo (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (tmo_clr),
      .en_i     (state_q == ST_FETCH),
      .expire_o (tmo_exp)
   );

   // State and datapath registers; sel resets to MOV so RA passes through unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         op_q    <= OP_MOV;
         sel_q   <= OP_MOV;
         err_q   <= ERR_OK;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         op_q    <= op_d;
         sel_q   <= sel_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic; ack is only looked at in FETCH, where instr_req is high
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      op_d    = op_q;
      sel_d   = sel_q;
      err_d   = err_q;
      tmo_clr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               pc_d    = bus.start_pc;
               err_d   = ERR_OK;
               tmo_clr = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (bus.instr_ack) begin
               op_d = bus.instr_data[2:0];
               if (bus.instr_data[HALT_BIT]) begin
                  state_d = ST_FIN;
               end else begin
                  sel_d   = bus.instr_data[2:0];
                  state_d = ST_EXEC;
               end
            end else if (tmo_exp) begin
               err_d   = ERR_TMO;
               state_d = ST_FIN;
            end
         end
         ST_EXEC: begin
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            if (pc_q == {PC_W{1'b1}}) begin
               err_d   = ERR_WRAP;
               state_d = ST_FIN;
            end else begin
               pc_d    = pc_q + 1'b1;
               tmo_clr = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Moore outputs: load enables exist only in WRITE, which never repeats back-to-back
   always_comb begin
      bus.instr_req  = (state_q == ST_FETCH);
      bus.instr_addr = pc_q;
      bus.sel        = sel_q;
      bus.ld_a       = (state_q == ST_WRITE) && (op_q != OP_MOV);
      bus.ld_b       = (state_q == ST_WRITE) && ((op_q == OP_MOV) || (op_q == OP_EXCH));
      bus.busy       = (state_q != ST_IDLE);
      bus.done       = (state_q == ST_FIN);
      bus.err        = err_q;
   end

endmodule

// File: tb/tb_blue_seq_ctrl.sv
// tb/tb_blue_seq_ctrl.sv - directed self-checking bench for blue_seq_ctrl
module tb_blue_seq_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   blue_seq_ctrl_if #(.PC_W(4)) bus ();

   blue_seq_ctrl #(.PC_W(4), .TMO_CYC(15)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [7:0] rom [16];
   int         rom_wait = 0;
   bit         no_ack   = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   int         done_cyc, nla, nlb, lda_cyc, max_run, consec, addr_chg, npulse;
   logic [1:0] pulses [4];
   logic [1:0] err_at_done;
   logic [2:0] sel_at_ld;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Instruction ROM responder: acks after rom_wait request cycles
   initial begin
      int wcnt;
      wcnt = 0;
      bus.instr_ack  = 1'b0;
      bus.instr_data = 8'h00;
      forever begin
         @(negedge clk);
         if (!bus.instr_req) begin
            wcnt = 0;
            bus.instr_ack  = 1'b0;
            bus.instr_data = 8'h00;
         end else begin
            if (!no_ack && wcnt >= rom_wait) begin
               bus.instr_ack  = 1'b1;
               bus.instr_data = rom[bus.instr_addr];
            end else begin
               bus.instr_ack  = 1'b0;
               bus.instr_data = 8'h00;
            end
            wcnt++;
         end
      end
   end

   // Pulse start, then sample once per cycle (negedge) until done or budget expires
   task automatic run(input logic [3:0] spc, input int budget, input int extra_c);
      logic       prev_ld, prev_req, ld;
      logic [3:0] prev_addr;
      int         req_run;
      done_cyc = -1; nla = 0; nlb = 0; lda_cyc = -1; max_run = 0;
      consec = 0; addr_chg = 0; npulse = 0; err_at_done = 2'b11; sel_at_ld = 3'bxxx;
      prev_ld = 1'b0; prev_req = 1'b0; prev_addr = '0; req_run = 0;
      for (int i = 0; i < 4; i++) pulses[i] = 2'b00;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.start_pc = spc;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
         if (extra_c != 0 && c == extra_c) begin
            bus.start    = 1'b1;
            bus.start_pc = spc + 4'd5;
         end
         if (extra_c != 0 && c == extra_c + 1) bus.start = 1'b0;
         ld = bus.ld_a | bus.ld_b;
         if (ld && prev_ld) consec++;
         if (ld && npulse < 4) begin
            pulses[npulse] = {bus.ld_a, bus.ld_b};
            npulse++;
         end
         if (bus.ld_a) begin
            nla++;
            lda_cyc   = c;
            sel_at_ld = bus.sel;
         end
         if (bus.ld_b) nlb++;
         if (bus.instr_req) begin
            if (prev_req && bus.instr_addr != prev_addr) addr_chg++;
            req_run = prev_req ? req_run + 1 : 1;
            if (req_run > max_run) max_run = req_run;
         end
         prev_ld   = ld;
         prev_req  = bus.instr_req;
         prev_addr = bus.instr_addr;
         if (bus.done) begin
            done_cyc    = c;
            err_at_done = bus.err;
            break;
         end
      end
      bus.start = 1'b0;
      chk("done_seen", 32'(done_cyc >= 0), 32'd1);
      @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_done", 32'(bus.done), 32'd0);
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.start_pc = 4'd0;
      for (int i = 0; i < 16; i++) rom[i] = 8'h80;

      // Reset values
      #2 rst_n = 1'b0;
      #10;
      chk("rst_req",  32'(bus.instr_req),  32'd0);
      chk("rst_addr", 32'(bus.instr_addr), 32'd0);
      chk("rst_sel",  32'(bus.sel),        32'h2);
      chk("rst_ld",   32'({bus.ld_a, bus.ld_b}), 32'd0);
      chk("rst_busy", 32'(bus.busy),       32'd0);
      chk("rst_done", 32'(bus.done),       32'd0);
      chk("rst_err",  32'(bus.err),        32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: ADD then HALT, zero-wait ROM
      rom[0] = 8'h04; rom[1] = 8'h80; rom_wait = 0;
      run(4'd0, 40, 0);
      chk("t1_done_cyc", 32'(done_cyc), 32'd5);
      chk("t1_lda_cyc",  32'(lda_cyc),  32'd3);
      chk("t1_nla",      32'(nla),      32'd1);
      chk("t1_nlb",      32'(nlb),      32'd0);
      chk("t1_sel",      32'(sel_at_ld), 32'h4);
      chk("t1_err",      32'(err_at_done), 32'd0);
      chk("t1_sel_hold", 32'(bus.sel),  32'h4);

      // 2: MOV, EXCH, HALT
      rom[0] = 8'h02; rom[1] = 8'h03; rom[2] = 8'h80;
      run(4'd0, 40, 0);
      chk("t2_done_cyc", 32'(done_cyc), 32'd8);
      chk("t2_nla",      32'(nla),      32'd1);
      chk("t2_nlb",      32'(nlb),      32'd2);
      chk("t2_mov_ld",   32'(pulses[0]), 32'h1);
      chk("t2_exch_ld",  32'(pulses[1]), 32'h3);
      chk("t2_consec",   32'(consec),   32'd0);
      chk("t2_sel_hold", 32'(bus.sel),  32'h3);

      // 3: three ROM wait cycles per fetch
      rom[0] = 8'h05; rom[1] = 8'h80; rom_wait = 3;
      run(4'd0, 60, 0);
      chk("t3_done_cyc", 32'(done_cyc), 32'd11);
      chk("t3_lda_cyc",  32'(lda_cyc),  32'd6);
      chk("t3_req_run",  32'(max_run),  32'd4);
      chk("t3_addr_chg", 32'(addr_chg), 32'd0);
      chk("t3_sel",      32'(sel_at_ld), 32'h5);

      // 4: fetch never acked -> timeout
      no_ack = 1'b1;
      run(4'd3, 60, 0);
      no_ack = 1'b0;
      chk("t4_done_cyc", 32'(done_cyc), 32'd16);
      chk("t4_err",      32'(err_at_done), 32'h1);
      chk("t4_req_run",  32'(max_run),  32'd15);
      chk("t4_no_ld",    32'(nla + nlb), 32'd0);
      chk("t4_err_hold", 32'(bus.err),  32'h1);

      // 5: last two addresses, no HALT -> wrap error after both execute
      rom[14] = 8'h07; rom[15] = 8'h07; rom_wait = 0;
      run(4'd14, 40, 0);
      chk("t5_done_cyc", 32'(done_cyc), 32'd7);
      chk("t5_nla",      32'(nla),      32'd2);
      chk("t5_nlb",      32'(nlb),      32'd0);
      chk("t5_err",      32'(err_at_done), 32'h2);
      chk("t5_consec",   32'(consec),   32'd0);
      chk("t5_err_hold", 32'(bus.err),  32'h2);

      // 6a: start re-pulsed while busy must be ignored
      rom[0] = 8'h05; rom[1] = 8'h80; rom_wait = 3;
      run(4'd0, 60, 2);
      chk("t6_done_cyc", 32'(done_cyc), 32'd11);
      chk("t6_addr_chg", 32'(addr_chg), 32'd0);
      chk("t6_nla",      32'(nla),      32'd1);
      chk("t6_err",      32'(err_at_done), 32'd0);

      // 6b: async reset in the middle of a waiting fetch
      rom[9] = 8'h07; rom[10] = 8'h80;
      run(4'd9, 40, 0);
      chk("t6_pre_sel", 32'(bus.sel), 32'h7);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.start_pc = 4'd9;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      chk("t6_in_fetch", 32'(bus.instr_req), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_req",  32'(bus.instr_req),  32'd0);
      chk("t6_rst_addr", 32'(bus.instr_addr), 32'd0);
      chk("t6_rst_sel",  32'(bus.sel),        32'h2);
      chk("t6_rst_busy", 32'(bus.busy),       32'd0);
      chk("t6_rst_done", 32'(bus.done),       32'd0);
      chk("t6_rst_ld",   32'({bus.ld_a, bus.ld_b}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Recovery after reset
      rom[0] = 8'h04; rom[1] = 8'h80; rom_wait = 0;
      run(4'd0, 40, 0);
      chk("t7_done_cyc", 32'(done_cyc), 32'd5);
      chk("t7_err",      32'(err_at_done), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
